// File: rtl/noc_vc_input_port_if.sv
// Link-side bundle of a router input port: flit push, allocator pop, per-VC status and credit return.
interface noc_vc_input_port_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 5,
    parameter int NUM_VC = 2,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
);
    logic [DATA_W-1:0]        data_i;
    logic                     write_en;
    logic [VC_W-1:0]          write_vc_i;
    logic                     shift;
    logic [VC_W-1:0]          shift_vc_i;
    logic [NUM_VC*DATA_W-1:0] data_o;
    logic [NUM_VC-1:0]        read_valid_o;
    logic [NUM_VC-1:0]        full_o;
    logic [NUM_VC*CNT_W-1:0]  count_o;
    logic                     credit_o;
    logic [VC_W-1:0]          credit_vc_o;
    logic                     overflow_err_o;
    logic                     underflow_err_o;

    // master drives the link and the allocator pop; slave is the input port
    modport master (
        output data_i, write_en, write_vc_i, shift, shift_vc_i,
        input  data_o, read_valid_o, full_o, count_o, credit_o, credit_vc_o,
               overflow_err_o, underflow_err_o
    );

    modport slave (
        input  data_i, write_en, write_vc_i, shift, shift_vc_i,
        output data_o, read_valid_o, full_o, count_o, credit_o, credit_vc_o,
               overflow_err_o, underflow_err_o
    );
endinterface

// File: rtl/noc_vc_input_port.sv
// Router input port: NUM_VC show-ahead circular FIFOs fed from one link, popped by the
// switch allocator one VC per cycle, with credit return and sticky error flags.
module noc_vc_input_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 5,
    parameter int NUM_VC = 2
) (
    input logic                clk,
    input logic                rst,
    noc_vc_input_port_if.slave port
);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a push (write_en) is taken at the edge only when its VC is in range and
    // not full at cycle start; a pop (shift) is taken only when its VC is in range and
    // non-empty at cycle start. Neither side waits: refused requests are dropped and flagged.

    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [CNT_W-1:0]  count [NUM_VC];

    logic [NUM_VC-1:0] push_v;
    logic [NUM_VC-1:0] pop_v;
    logic              push_err;
    logic              pop_err;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        // DEPTH need not be a power of two, so the wrap is explicit
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push_v = '0;
        pop_v  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_v[v] = port.write_en && (port.write_vc_i == VC_W'(v)) &&
                        (count[v] != CNT_W'(DEPTH));
            pop_v[v]  = port.shift && (port.shift_vc_i == VC_W'(v)) &&
                        (count[v] != '0);
        end
        push_err = port.write_en && (push_v == '0);
        pop_err  = port.shift && (pop_v == '0);
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_v[v]) begin
                mem[v][wr_ptr[v]] <= port.data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
            port.credit_o        <= 1'b0;
            port.credit_vc_o     <= '0;
            port.overflow_err_o  <= 1'b0;
            port.underflow_err_o <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_v[v]) begin
                    wr_ptr[v] <= next_ptr(wr_ptr[v]);
                end
                if (pop_v[v]) begin
                    rd_ptr[v] <= next_ptr(rd_ptr[v]);
                end
                count[v] <= count[v] + CNT_W'(push_v[v]) - CNT_W'(pop_v[v]);
            end
            port.credit_o <= (pop_v != '0);
            if (pop_v != '0) begin
                port.credit_vc_o <= port.shift_vc_i;
            end
            if (push_err) begin
                port.overflow_err_o <= 1'b1;
            end
            if (pop_err) begin
                port.underflow_err_o <= 1'b1;
            end
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_out
        assign port.data_o[v*DATA_W +: DATA_W] = mem[v][rd_ptr[v]];
        assign port.count_o[v*CNT_W +: CNT_W]  = count[v];
        assign port.read_valid_o[v]            = (count[v] != '0);
        assign port.full_o[v]                  = (count[v] == CNT_W'(DEPTH));
    end

endmodule

// File: doc/noc_vc_input_port.md
Name: noc_vc_input_port

Overview:
- Parametrised router input port with NUM_VC independent virtual-channel FIFOs, each DEPTH entries of DATA_W bits, sharing one link input.
- Incoming flits are steered by VC id. The switch allocator pops one VC per cycle.
- Each successful pop returns a credit upstream.
- Adds per-VC occupancy, full flags and sticky overflow/underflow error flags.

Parameters:
- DATA_W, 16, flit width in bits.
- DEPTH, 5, entries per VC FIFO (>=2, need not be a power of two).
- NUM_VC, 2, number of virtual channels (>=1).
- VC_W, max(1,$clog2(NUM_VC)), derived; VC id width.
- CNT_W, $clog2(DEPTH+1), derived; occupancy counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- data_i  input  DATA_W  incoming flit.
- write_en  input  1  push data_i into VC write_vc_i.
- write_vc_i  input  VC_W  target VC of push.
- shift  input  1  pop head of VC shift_vc_i.
- shift_vc_i  input  VC_W  VC to pop.
- data_o  output  NUM_VC*DATA_W  head flit of each VC; VC v at bits [v*DATA_W +: DATA_W].
- read_valid_o  output  NUM_VC  VC v non-empty.
- full_o  output  NUM_VC  VC v holds DEPTH entries.
- count_o  output  NUM_VC*CNT_W  occupancy of each VC.
- credit_o  output  1  one-cycle credit-return pulse.
- credit_vc_o  output  VC_W  VC of returned credit.
- overflow_err_o  output  1  sticky: push attempted to a full VC.
- underflow_err_o  output  1  sticky: pop attempted from an empty VC.

Behaviour:
- Reset:
  - rst sampled high at a clk edge clears all read/write pointers and counts, credit_o, credit_vc_o, overflow_err_o and underflow_err_o.
  - Next cycle: read_valid_o=0, full_o=0, count_o=0.
  - data_o contents are don't-care while read_valid_o=0.
  - Reset mid-traffic discards all stored flits and suppresses any credit pending from that edge.
- Storage:
  - Per-VC circular buffer of DEPTH entries with read/write pointers.
  - Pointers wrap from DEPTH-1 to 0; the non-power-of-2 wrap must be explicit.
- Show-ahead read:
  - data_o slice for VC v is combinational from that VC's read pointer.
  - A valid head is visible in the same cycle read_valid_o[v]=1.
  - No read latency; the flit leaves when the shift edge occurs.
- Push:
  - Accepted at the clk edge iff write_en=1 and full_o[write_vc_i]=0, both evaluated at cycle start.
  - write_vc_i >= NUM_VC: push dropped, overflow_err_o set.
  - Push to a full VC is dropped and sets overflow_err_o, even if the same VC is popped that cycle. No pass-through on full.
  - The pushed flit becomes visible on data_o the next cycle: write-to-read latency 1.
- Pop:
  - Performed iff shift=1 and read_valid_o[shift_vc_i]=1.
  - Pop from an empty VC, or with shift_vc_i >= NUM_VC: no state change, underflow_err_o set.
  - An empty VC with simultaneous push and pop gets the push and flags underflow. No bypass.
- Simultaneous push and pop, same non-empty, non-full VC: both happen and count is unchanged.
- Different VCs: push and pop are independent.
- Count: count_o[v] = previous count + push_v - pop_v and always stays within 0..DEPTH. full_o[v] = (count==DEPTH). read_valid_o[v] = (count!=0).
- Credit:
  - credit_o registered; it is 1 the cycle after each successful pop, with credit_vc_o = the popped VC, else 0.
  - credit_vc_o holds its last value while credit_o=0.
  - Back-to-back pops give back-to-back credit pulses.
- Error flags: sticky until rst. They never block other operations.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> read_valid_o=00, full_o=00, count_o all 0, credit_o=0, both err flags 0.
- Fill VC1: push flits 0x0101..0x0105 to VC1 on 5 consecutive cycles -> full_o=10, count VC1=5, data_o VC1 slice=0x0101. 6th push 0x0106 -> dropped, overflow_err_o=1, count stays 5.
- Drain with wrap: pop VC1 five times -> heads 0x0101..0x0105 in order, credit_o=1 with credit_vc_o=1 on the 5 following cycles. Then push 0x0AAA -> head 0x0AAA after pointer wrap, count=1.
- Concurrent same VC: VC0 holds 2 flits (0x0011, 0x0022); push 0x0033 and pop VC0 in the same cycle -> count stays 2, head becomes 0x0022, one credit for VC0.
- Concurrent different VCs: push 0x00B0 to VC0 while popping VC1 holding 0x00C0 -> VC0 count+1, VC1 empty, credit_vc_o=1, no error.
- Underflow and reset mid-operation: pop empty VC0 -> underflow_err_o=1, counts unchanged. Then with both VCs holding data, assert rst in the same cycle as a pop -> all counts 0, no credit pulse, errors cleared.
